aes_decrypt_sequencer: RTL and testbench

AES_DECRYPT_SEQUENCER -- requirements
Module: aes_decrypt_sequencer

---
 rtl/aes_decrypt_sequencer_pkg.sv | 34 +++
 rtl/aes_decrypt_sequencer_if.sv | 32 +++
 rtl/aes_stage_watchdog.sv | 33 +++
 rtl/aes_decrypt_sequencer.sv | 100 ++++++++++
 tb/tb_aes_decrypt_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_decrypt_sequencer_pkg.sv
// Shared AES decrypt definitions: sequencer states, round/timeout defaults and
// the inverse-cipher op ordering used by the sequencer, round stages and output mux.
package aes_decrypt_sequencer_pkg;

    localparam int unsigned AES_NR      = 10;
    localparam int unsigned AES_TIMEOUT = 255;
    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_RND_W   = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHIFT,
        SUB,
        MIX,
        FIN
    } seq_state_t;

    // Successor of an op state; rnd is the round count held while in that op.
    function automatic seq_state_t next_op(input seq_state_t op,
                                           input logic [AES_RND_W-1:0] rnd,
                                           input logic [AES_RND_W-1:0] nr);
        case (op)
            ADD:     return (rnd == '0) ? SHIFT : ((rnd < nr) ? MIX : FIN);
            SHIFT:   return SUB;
            SUB:     return ADD;
            MIX:     return SHIFT;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/aes_decrypt_sequencer_if.sv
// Request/result and round-stage handshake bundle of the AES decrypt sequencer.
interface aes_decrypt_sequencer_if;
    import aes_decrypt_sequencer_pkg::*;

    logic                 Start;
    aes_block_t           CipherText;
    logic                 Ry;
    aes_block_t           Text;
    aes_block_t           StateText;
    logic                 AddEn;
    logic                 ShiftEn;
    logic                 SubEn;
    logic                 MixEn;
    logic [AES_RND_W-1:0] RoundKeySel;
    aes_block_t           PlainText;
    logic                 Busy;
    logic                 Done;
    logic                 Err;

    modport master (
        output Start, CipherText, Ry, Text,
        input  StateText, AddEn, ShiftEn, SubEn, MixEn, RoundKeySel,
        input  PlainText, Busy, Done, Err
    );

    modport slave (
        input  Start, CipherText, Ry, Text,
        output StateText, AddEn, ShiftEn, SubEn, MixEn, RoundKeySel,
        output PlainText, Busy, Done, Err
    );

endinterface

// File: rtl/aes_stage_watchdog.sv
// Stage-ready watchdog: reloaded by an enable pulse, counts down while the
// sequencer waits for Ry, flags expiry on the last permitted waiting cycle.
module aes_stage_watchdog
    import aes_decrypt_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = AES_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT);
        end else if (!run) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire = run && (count == CW'(1));

endmodule

// File: rtl/aes_decrypt_sequencer.sv
// AES-128 inverse-cipher sequencer: walks the round stages in decrypt order,
// pulsing one stage enable per op and latching each stage result on Ry.
module aes_decrypt_sequencer
    import aes_decrypt_sequencer_pkg::*;
#(
    parameter int unsigned NR      = AES_NR,
    parameter int unsigned TIMEOUT = AES_TIMEOUT
) (
    input logic                    clk,
    input logic                    rst_n,
    aes_decrypt_sequencer_if.slave bus
);

    localparam logic [AES_RND_W-1:0] NR_L = AES_RND_W'(NR);

    seq_state_t           state;
    seq_state_t           succ;
    logic [AES_RND_W-1:0] rnd;
    logic                 pulse;
    logic                 waiting;
    logic                 expire;

    // Ry is only honoured after the enable pulse cycle of the current op.
    assign pulse   = bus.AddEn | bus.ShiftEn | bus.SubEn | bus.MixEn;
    assign waiting = (state inside {ADD, SHIFT, SUB, MIX}) && !pulse;
    assign succ    = next_op(state, rnd, NR_L);

    aes_stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pulse),
        .run   (waiting),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rnd             <= '0;
            bus.StateText   <= '0;
            bus.PlainText   <= '0;
            bus.RoundKeySel <= '0;
            bus.AddEn       <= 1'b0;
            bus.ShiftEn     <= 1'b0;
            bus.SubEn       <= 1'b0;
            bus.MixEn       <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.Done        <= 1'b0;
            bus.Err         <= 1'b0;
        end else begin
            bus.AddEn   <= 1'b0;
            bus.ShiftEn <= 1'b0;
            bus.SubEn   <= 1'b0;
            bus.MixEn   <= 1'b0;
            bus.Done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state           <= ADD;
                        rnd             <= '0;
                        bus.StateText   <= bus.CipherText;
                        bus.RoundKeySel <= NR_L;
                        bus.AddEn       <= 1'b1;
                        bus.Busy        <= 1'b1;
                        bus.Err         <= 1'b0;
                    end
                end
                ADD, SHIFT, SUB, MIX: begin
                    if (waiting && bus.Ry) begin
                        bus.StateText <= bus.Text;
                        state         <= succ;
                        bus.AddEn     <= (succ == ADD);
                        bus.ShiftEn   <= (succ == SHIFT);
                        bus.SubEn     <= (succ == SUB);
                        bus.MixEn     <= (succ == MIX);
                        // ADD is only ever entered from SUB, where rnd already names this round.
                        if (succ == ADD) begin
                            bus.RoundKeySel <= NR_L - rnd;
                        end
                        if (state == MIX || (state == ADD && rnd == '0)) begin
                            rnd <= rnd + AES_RND_W'(1);
                        end
                    end else if (expire) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                        bus.Err  <= 1'b1;
                    end
                end
                FIN: begin
                    bus.PlainText <= bus.StateText;
                    bus.Done      <= 1'b1;
                    bus.Busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer with behavioural AES round stages and a
// forward-cipher reference that produces ciphertext for known plaintext.
module tb_aes_decrypt_sequencer;
    import aes_decrypt_sequencer_pkg::*;

    localparam int unsigned NR  = 10;
    localparam int unsigned TMO = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_decrypt_sequencer_if bus();

    aes_decrypt_sequencer #(.NR(NR), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk  [NR+1];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the field inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gm(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic int bp(input int r, input int c);
        return 127 - 8 * (r + 4 * c);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[bp(r, c) -: 8] = s[bp(r, inv ? (c - r + 4) % 4 : (c + r) % 4) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc ^= gm(s[bp(j, c) -: 8], cf[(j - r + 4) % 4]);
                o[bp(r, c) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r < int'(NR); r++)
            s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[NR];
    endfunction

    task automatic build_tables(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 256; i++) begin
            sb[i] = sbox_calc(8'(i));
            isb[sb[i]] = 8'(i);
        end
        for (int i = 0; i < 4 * (int'(NR) + 1); i++) begin
            if (i < 4) begin
                w[i] = key[127-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                    rcon = xt(rcon);
                end
                w[i] = w[i-4] ^ t;
            end
        end
        for (int r = 0; r <= int'(NR); r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Behavioural round stages: respond to each enable pulse after lat cycles.
    int           lat         = 1;
    int           rsp_pulses  = 0;
    int           withhold_at = -1;
    bit           spur        = 1'b0;
    bit           poke_idle   = 1'b0;
    int           onehot_err  = 0;
    int           countdown   = 0;
    logic [127:0] pend;
    int           op_log   [$];
    int           ksel_log [$];

    always @(negedge clk) begin
        bus.Ry = 1'b0;
        if (poke_idle) begin
            bus.Ry    = 1'b1;
            bus.Text  = {$urandom, $urandom, $urandom, $urandom};
            poke_idle = 1'b0;
        end
        if (!rst_n) countdown = 0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                bus.Ry   = 1'b1;
                bus.Text = pend;
            end
        end
        if (rst_n && (bus.AddEn | bus.ShiftEn | bus.SubEn | bus.MixEn)) begin
            rsp_pulses++;
            if ((int'(bus.AddEn) + int'(bus.ShiftEn) + int'(bus.SubEn) + int'(bus.MixEn)) != 1)
                onehot_err++;
            if (bus.AddEn) begin
                pend = bus.StateText ^ rk[int'(bus.RoundKeySel)];
                op_log.push_back(0);
                ksel_log.push_back(int'(bus.RoundKeySel));
            end else if (bus.ShiftEn) begin
                pend = shift_rows(bus.StateText, 1'b1);
                op_log.push_back(1);
            end else if (bus.SubEn) begin
                pend = sub_bytes(bus.StateText, 1'b1);
                op_log.push_back(2);
            end else begin
                pend = mix_cols(bus.StateText, 1'b1);
                op_log.push_back(3);
            end
            if (rsp_pulses != withhold_at) countdown = lat;
            if (spur) begin
                bus.Ry   = 1'b1;
                bus.Text = ~pend;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ctrl_vec();
        return {bus.RoundKeySel, bus.AddEn, bus.ShiftEn, bus.SubEn, bus.MixEn, bus.Busy, bus.Done, bus.Err};
    endfunction

    logic [127:0] last_pt;

    // Called at negedge number n0 after the accepting edge.
    task automatic finish_op(input string tag, input logic [127:0] exp_pt, input int l, input int n0);
        int n   = n0;
        int gap = 0;
        check({tag, "_busy"}, 128'(bus.Busy), 128'(1));
        check({tag, "_err_clr"}, 128'(bus.Err), 128'(0));
        while (bus.Done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.Done !== 1'b1 && bus.Busy !== 1'b1) gap++;
        end
        check({tag, "_cycles"}, 128'(n - 1), 128'(4 * NR * (l + 1) + 1));
        check({tag, "_busy_gap"}, 128'(gap), 128'(0));
        check({tag, "_pt"}, bus.PlainText, exp_pt);
        check({tag, "_busy_end"}, 128'(bus.Busy), 128'(0));
        check({tag, "_err"}, 128'(bus.Err), 128'(0));
        last_pt = exp_pt;
    endtask

    task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt, input int l);
        lat = l;
        @(negedge clk);
        bus.CipherText = ct;
        bus.Start      = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        finish_op(tag, exp_pt, l, 1);
    endtask

    task automatic wait_pulses(input int target, output int seen);
        int n = 0;
        seen = 0;
        while (n < 3000) begin
            if (bus.AddEn | bus.ShiftEn | bus.SubEn | bus.MixEn) seen++;
            if (seen == target) break;
            @(negedge clk);
            n++;
        end
    endtask

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] pt, ct, st;
        int           k, seen, mism, dones;
        int           exp_ops [$];

        bus.Start = 1'b0;
        bus.CipherText = '0;
        bus.Ry = 1'b0;
        bus.Text = '0;
        build_tables(128'h000102030405060708090a0b0c0d0e0f);

        repeat (3) @(negedge clk);
        check("rst_state", bus.StateText, '0);
        check("rst_pt", bus.PlainText, '0);
        check("rst_ctrl", 128'(ctrl_vec()), '0);
        rst_n = 1'b1;

        run_op("c1", C1_CT, C1_PT, 1);

        // Stage order, key indices and L=3 latency.
        op_log.delete();
        ksel_log.delete();
        pt = {$urandom, $urandom, $urandom, $urandom};
        run_op("order", encrypt(pt), pt, 3);
        exp_ops.push_back(0);
        for (int r = 1; r < int'(NR); r++) begin
            exp_ops.push_back(1); exp_ops.push_back(2); exp_ops.push_back(0); exp_ops.push_back(3);
        end
        exp_ops.push_back(1); exp_ops.push_back(2); exp_ops.push_back(0);
        check("order_len", 128'(op_log.size()), 128'(4 * NR));
        mism = 0;
        for (int i = 0; i < exp_ops.size() && i < op_log.size(); i++)
            if (op_log[i] != exp_ops[i]) mism++;
        check("order_seq", 128'(mism), '0);
        check("ksel_len", 128'(ksel_log.size()), 128'(NR + 1));
        mism = 0;
        for (int i = 0; i < ksel_log.size(); i++)
            if (ksel_log[i] != int'(NR) - i) mism++;
        check("ksel_seq", 128'(mism), '0);
        check("onehot", 128'(onehot_err), '0);

        // Ry coincident with every enable pulse must be ignored.
        spur = 1'b1;
        lat  = 1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(pt);
        @(negedge clk);
        bus.CipherText = ct;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        check("spur_state", bus.StateText, ct);
        finish_op("spur", pt, 1, 2);
        spur = 1'b0;

        // Start held high: one decrypt, next accepted right after Done.
        pt = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.CipherText = encrypt(pt);
        bus.Start = 1'b1;
        @(negedge clk);
        finish_op("hold1", pt, 1, 1);
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(pt);
        bus.CipherText = ct;
        @(negedge clk);
        check("hold2_accept", bus.StateText, ct);
        bus.Start = 1'b0;
        finish_op("hold2", pt, 1, 1);

        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_op("rand", encrypt(pt), pt, int'($urandom_range(1, 4)));
        end

        // Ry while idle.
        st = bus.StateText;
        poke_idle = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ry_state", bus.StateText, st);
        check("idle_ry_ctrl", 128'(ctrl_vec() & 11'h07f), '0);

        // Timeout on the 5th pulse.
        lat = 1;
        withhold_at = rsp_pulses + 5;
        @(negedge clk);
        bus.CipherText = {$urandom, $urandom, $urandom, $urandom};
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_pulses(5, seen);
        check("tmo_pulses", 128'(seen), 128'(5));
        k = 0;
        dones = 0;
        while (bus.Err !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
            if (bus.Done === 1'b1) dones++;
        end
        check("tmo_cycles", 128'(k), 128'(TMO + 1));
        check("tmo_busy", 128'(bus.Busy), '0);
        check("tmo_done", 128'(dones), '0);
        check("tmo_pt", bus.PlainText, last_pt);
        withhold_at = -1;
        repeat (3) @(negedge clk);
        check("tmo_sticky", 128'(bus.Err), 128'(1));
        pt = {$urandom, $urandom, $urandom, $urandom};
        run_op("after_tmo", encrypt(pt), pt, 2);

        // Reset for one cycle during round 5.
        lat = 1;
        @(negedge clk);
        bus.CipherText = C1_CT;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_pulses(18, seen);
        check("mid_pulses", 128'(seen), 128'(18));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_state", bus.StateText, '0);
        check("mid_rst_pt", bus.PlainText, '0);
        check("mid_rst_ctrl", 128'(ctrl_vec()), '0);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) dones++;
        end
        check("mid_no_done", 128'(dones), '0);
        run_op("c1_restart", C1_CT, C1_PT, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no end of test, required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
